// File: rtl/ahb_cmd_master.sv
// -----------------------------------------------------------------------------
// ahb_cmd_master
//
// AHB-lite master that turns a local valid/ready command stream into pipelined
// single NONSEQ transfers and returns read data on a buffered valid/ready
// response port.
//
// Data flow:
//   cmd port -> command FIFO -> address stage -> data stage -> response FIFO
//
// The address phase of transfer N overlaps the data phase of transfer N-1.
// Reads are only launched while a slot is guaranteed free in the response
// FIFO, so read data is never dropped. When no slot is free the master drives
// IDLE until the consumer drains responses.
//
// Ports:
//   hclk, hreset              bus clock (rising edge); async active-high reset
//   cmd_valid / cmd_ready     command handshake (cmd_ready is a flop)
//   cmd_write, cmd_addr,      command payload; cmd_wdata is ignored for reads
//   cmd_wdata
//   rsp_valid / rsp_ready     response handshake
//   rsp_rdata                 read data, in command order
//   htrans, hwrite, haddr     address phase outputs (IDLE / NONSEQ only)
//   hwdata                    write data of the current data phase
//   hready, hrdata            slave ready and read data
// -----------------------------------------------------------------------------
module ahb_cmd_master #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 4
) (
  input  logic              hclk,
  input  logic              hreset,
  // command port
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  // response port
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  // AHB-lite master interface
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [ADDR_W-1:0] haddr,
  output logic [DATA_W-1:0] hwdata,
  input  logic              hready,
  input  logic [DATA_W-1:0] hrdata
);

  localparam int CMD_AW = $clog2(CMD_DEPTH);
  localparam int RSP_AW = $clog2(RSP_DEPTH);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // Read slots available in total: buffered responses plus reads on the bus.
  localparam logic [RSP_AW+1:0] RSP_CREDITS = (RSP_AW + 2)'(RSP_DEPTH);

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  cmd_t              cmd_mem [CMD_DEPTH];
  logic [DATA_W-1:0] rsp_mem [RSP_DEPTH];

  logic [CMD_AW:0]   cmd_wr_ptr_q, cmd_wr_ptr_d;
  logic [CMD_AW:0]   cmd_rd_ptr_q, cmd_rd_ptr_d;
  logic              cmd_ready_q,  cmd_ready_d;

  logic [RSP_AW:0]   rsp_wr_ptr_q, rsp_wr_ptr_d;
  logic [RSP_AW:0]   rsp_rd_ptr_q, rsp_rd_ptr_d;

  // address stage
  logic              a_vld_q,   a_vld_d;
  logic              a_wr_q,    a_wr_d;
  logic [ADDR_W-1:0] a_addr_q,  a_addr_d;
  logic [DATA_W-1:0] a_wdata_q, a_wdata_d;
  // data stage
  logic              d_vld_q,   d_vld_d;
  logic              d_wr_q,    d_wr_d;
  logic [DATA_W-1:0] d_wdata_q, d_wdata_d;

  // ---------------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------------
  cmd_t              cmd_in;
  cmd_t              cmd_head;
  logic              cmd_push;
  logic              cmd_pop;
  logic              cmd_empty;
  logic              cmd_full_next;

  logic              rsp_push;
  logic              rsp_pop;
  logic              rsp_empty;
  logic [RSP_AW:0]   rsp_count;
  logic [RSP_AW+1:0] rd_used;
  logic              rd_credit_ok;
  logic              a_rd;
  logic              d_rd;
  logic              launch;

  assign cmd_in   = '{wr: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
  assign cmd_head = cmd_mem[cmd_rd_ptr_q[CMD_AW-1:0]];

  // cmd_ready_q is low in reset, which also blocks pushes during reset.
  assign cmd_push  = cmd_valid & cmd_ready_q;
  assign cmd_empty = (cmd_wr_ptr_q == cmd_rd_ptr_q);

  assign rsp_empty = (rsp_wr_ptr_q == rsp_rd_ptr_q);
  assign rsp_count = rsp_wr_ptr_q - rsp_rd_ptr_q;
  assign rsp_pop   = ~rsp_empty & rsp_ready;

  // Reads currently occupying the bus pipeline. The data-stage read is still
  // counted on the edge that pushes it, and a same-edge response pop is not
  // credited until the next cycle; both keep the count conservative.
  assign a_rd = a_vld_q & ~a_wr_q;
  assign d_rd = d_vld_q & ~d_wr_q;

  assign rd_used      = {1'b0, rsp_count}
                      + {{(RSP_AW + 1){1'b0}}, a_rd}
                      + {{(RSP_AW + 1){1'b0}}, d_rd};
  assign rd_credit_ok = (rd_used < RSP_CREDITS);

  // Writes need no response slot and may always launch.
  assign launch   = ~cmd_empty & (cmd_head.wr | rd_credit_ok);
  assign cmd_pop  = hready & launch;
  assign rsp_push = hready & d_rd;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; an unassigned path would infer a latch.
  always_comb begin
    cmd_wr_ptr_d = cmd_wr_ptr_q + {{CMD_AW{1'b0}}, cmd_push};
    cmd_rd_ptr_d = cmd_rd_ptr_q + {{CMD_AW{1'b0}}, cmd_pop};
    rsp_wr_ptr_d = rsp_wr_ptr_q + {{RSP_AW{1'b0}}, rsp_push};
    rsp_rd_ptr_d = rsp_rd_ptr_q + {{RSP_AW{1'b0}}, rsp_pop};

    // Full when pointers differ only in the wrap bit. Evaluated on the next
    // pointer values so cmd_ready can be a flop with no cmd_valid path.
    cmd_full_next = (cmd_wr_ptr_d[CMD_AW] != cmd_rd_ptr_d[CMD_AW]) &&
                    (cmd_wr_ptr_d[CMD_AW-1:0] == cmd_rd_ptr_d[CMD_AW-1:0]);
    cmd_ready_d   = ~cmd_full_next;
  end

  // Pipeline advance. With hready low every stage register holds.
  always_comb begin
    a_vld_d   = a_vld_q;
    a_wr_d    = a_wr_q;
    a_addr_d  = a_addr_q;
    a_wdata_d = a_wdata_q;
    d_vld_d   = d_vld_q;
    d_wr_d    = d_wr_q;
    d_wdata_d = d_wdata_q;

    if (hready) begin
      d_vld_d   = a_vld_q;
      d_wr_d    = a_vld_q & a_wr_q;
      d_wdata_d = a_wdata_q;

      if (launch) begin
        a_vld_d   = 1'b1;
        a_wr_d    = cmd_head.wr;
        a_addr_d  = cmd_head.addr;
        a_wdata_d = cmd_head.wdata;
      end else begin
        a_vld_d   = 1'b0;
        a_wr_d    = 1'b0;
        a_addr_d  = '0;
        a_wdata_d = '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its _d value from before the edge, independent of statement order.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      cmd_wr_ptr_q <= '0;
      cmd_rd_ptr_q <= '0;
      cmd_ready_q  <= 1'b0;
      rsp_wr_ptr_q <= '0;
      rsp_rd_ptr_q <= '0;
      a_vld_q      <= 1'b0;
      a_wr_q       <= 1'b0;
      a_addr_q     <= '0;
      a_wdata_q    <= '0;
      d_vld_q      <= 1'b0;
      d_wr_q       <= 1'b0;
      d_wdata_q    <= '0;
    end else begin
      cmd_wr_ptr_q <= cmd_wr_ptr_d;
      cmd_rd_ptr_q <= cmd_rd_ptr_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_wr_ptr_q <= rsp_wr_ptr_d;
      rsp_rd_ptr_q <= rsp_rd_ptr_d;
      a_vld_q      <= a_vld_d;
      a_wr_q       <= a_wr_d;
      a_addr_q     <= a_addr_d;
      a_wdata_q    <= a_wdata_d;
      d_vld_q      <= d_vld_d;
      d_wr_q       <= d_wr_d;
      d_wdata_q    <= d_wdata_d;
    end
  end

  // NOTE: FIFO storage is not reset; the pointers define which entries are
  // live, and outputs derived from storage are masked while a FIFO is empty.
  always_ff @(posedge hclk) begin
    if (cmd_push) begin
      cmd_mem[cmd_wr_ptr_q[CMD_AW-1:0]] <= cmd_in;
    end
    if (rsp_push) begin
      rsp_mem[rsp_wr_ptr_q[RSP_AW-1:0]] <= hrdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = ~rsp_empty;
  assign rsp_rdata = rsp_empty ? '0 : rsp_mem[rsp_rd_ptr_q[RSP_AW-1:0]];

  assign htrans = a_vld_q ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign hwrite = a_vld_q & a_wr_q;
  assign haddr  = a_vld_q ? a_addr_q : '0;
  assign hwdata = d_wr_q ? d_wdata_q : '0;

endmodule
